mux4x1_sel: RTL and testbench
=============================

// Module: mux4x1_sel
// PURPOSE
// - 4-input, WIDTH-bit multiplexer. Output y selects a/b/c/d by 2-bit sel.
// - The y path is purely combinational, for use as a glue-logic selector in datapaths.
// - A registered copy (y_q, sel_q) serves synchronous consumers.
// - Optional parity output.
// PARAMETERS
// - WIDTH   1   data width of a, b, c, d, y, y_q
// PORTS
// - clk      in   1      rising-edge clock, single clock domain
// - rst      in   1      synchronous reset, active-high
// - a        in   WIDTH  data input 0, selected when sel=2'b00
// - b        in   WIDTH  data input 1, selected when sel=2'b01
// - c        in   WIDTH  data input 2, selected when sel=2'b10
// - d        in   WIDTH  data input 3, selected when sel=2'b11
// - sel      in   2      select
// - y        out  WIDTH  combinational selected data
// - y_q      out  WIDTH  y registered on clk
// - sel_q    out  2      sel registered on clk
// - par_q    out  1      registered even parity (^y); present only with MUX4_PARITY_EN
// BEHAVIOUR
// - y: zero latency, no clock involvement.
//   - 00->a, 01->b, 10->c, 11->d.
//   - Changes within the same delta as any input or sel change.
// - Unselected inputs never affect y.
//   - Example: a=X, sel=01, b=1 -> y=1.
// - A selected input carrying X/Z propagates to y unchanged.
// - sel containing any X/Z bit -> y = all-X, in simulation only.
//   - Implement with a case statement plus a default branch that assigns 'x.
// - Registered path, on each rising clk edge:
//   - rst=1 -> y_q=0, sel_q=2'b00, par_q=0. Reset has priority over data.
//   - rst=0 -> y_q<=y, sel_q<=sel, par_q<=^y.
// - Registered-path latency is exactly 1 cycle: y_q at edge N equals y just before edge N.
// - Reset affects only registered outputs; y stays live during reset.
// - No handshake, no state machine, no internal storage beyond the output registers.
// - Deassertion of rst mid-stream: the first post-reset edge captures the current y.
// CONFIGURATION
// - Macro MUX4_PARITY_EN:
//   - Defined: par_q port exists and is the registered XOR-reduction of y (reset 0).
//   - Undefined: par_q port and its flop are absent; all other behaviour is identical.
// STRUCTURE
// - Package mux4x1_pkg:
//   - typedef logic [1:0] mux_sel_t.
//   - Constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
// - Sub-module mux4x1_comb: pure combinational select (a,b,c,d,sel -> y), WIDTH-parameterised.
//   - The top instantiates it and adds the output registers.
// TESTING
// - a=0,b=1,c=0,d=1; sel 00,01,10,11 in 5 ns steps -> y = 0,1,0,1.
// - a=1,b=0,c=1,d=0; sel 00,01,10,11 -> y = 1,0,1,0.
// - a=X,b=1,c=0,d=0:
//   - sel=00 -> y=X.
//   - sel=01 -> y=1 (X on an unselected input is masked).
// - rst=1 for 2 edges with sel=01,b=1 -> y_q=0, sel_q=00 while y=1.
//   - rst=0 -> next edge y_q=1, sel_q=01.
// - Change sel between edges -> y updates immediately; y_q updates only at the next rising edge.
// - WIDTH=8 with MUX4_PARITY_EN: a=8'hA5, sel=00 -> y=8'hA5, next edge y_q=8'hA5, par_q=0.
//   - Then d=8'h01, sel=11 -> par_q=1.

Source files
------------

// File: rtl/mux4x1_pkg.sv
// rtl/mux4x1_pkg.sv - select type and select-code constants shared by the 4:1 mux files
package mux4x1_pkg;

    typedef logic [1:0] mux_sel_t;

    localparam mux_sel_t SEL_A = 2'b00;
    localparam mux_sel_t SEL_B = 2'b01;
    localparam mux_sel_t SEL_C = 2'b10;
    localparam mux_sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux4x1_comb.sv
// rtl/mux4x1_comb.sv - purely combinational WIDTH-bit 4:1 select
module mux4x1_comb
    import mux4x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // An unknown select poisons the whole output in simulation rather than
    // silently picking one input.
    always_comb begin
        y = '0;
        case (sel)
            SEL_A:   y = a;
            SEL_B:   y = b;
            SEL_C:   y = c;
            SEL_D:   y = d;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux4x1_sel.sv
// rtl/mux4x1_sel.sv - 4:1 mux with live output plus registered y/sel copies; MUX4_PARITY_EN adds par_q
module mux4x1_sel
    import mux4x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [1:0]       sel_q
`ifdef MUX4_PARITY_EN
    ,
    output logic             par_q
`endif
);

    logic [WIDTH-1:0] y_d;
    mux_sel_t         sel_d;

    mux4x1_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .sel(sel),
        .y  (y)
    );

    always_comb begin
        y_d   = y;
        sel_d = sel;
    end

    // Reset only clears the registered copies; y keeps following the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            sel_q <= SEL_A;
        end else begin
            y_q   <= y_d;
            sel_q <= sel_d;
        end
    end

`ifdef MUX4_PARITY_EN
    logic par_d;

    always_comb begin
        par_d = ^y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux4x1_sel.sv
// tb/tb_mux4x1_sel.sv - directed self-checking bench for mux4x1_sel (WIDTH=8)
module tb_mux4x1_sel;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a, b, c, d;
    logic [1:0]   sel;
    logic [W-1:0] y, y_q;
    logic [1:0]   sel_q;
`ifdef MUX4_PARITY_EN
    logic         par_q;
`endif

    int n_cmp;
    int n_bad;

    mux4x1_sel #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .sel  (sel),
        .y    (y),
        .y_q  (y_q),
        .sel_q(sel_q)
`ifdef MUX4_PARITY_EN
        ,
        .par_q(par_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        a = 8'h00; b = 8'h01; c = 8'h00; d = 8'h00; sel = 2'b01;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (y_q !== 8'h00) begin
            n_bad++; $display("FAIL reset_y_q: got %h want %h", y_q, 8'h00);
        end
        n_cmp++;
        if (sel_q !== 2'b00) begin
            n_bad++; $display("FAIL reset_sel_q: got %b want %b", sel_q, 2'b00);
        end
        n_cmp++;
        if (y !== 8'h01) begin
            n_bad++; $display("FAIL reset_y_live: got %h want %h", y, 8'h01);
        end
`ifdef MUX4_PARITY_EN
        n_cmp++;
        if (par_q !== 1'b0) begin
            n_bad++; $display("FAIL reset_par_q: got %b want %b", par_q, 1'b0);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (y_q !== 8'h01) begin
            n_bad++; $display("FAIL release_y_q: got %h want %h", y_q, 8'h01);
        end
        n_cmp++;
        if (sel_q !== 2'b01) begin
            n_bad++; $display("FAIL release_sel_q: got %b want %b", sel_q, 2'b01);
        end
    endtask

    task automatic test_patterns();
        logic [W-1:0] exp0 [4];
        logic [W-1:0] exp1 [4];
        exp0 = '{8'h00, 8'h01, 8'h00, 8'h01};
        exp1 = '{8'h01, 8'h00, 8'h01, 8'h00};
        @(negedge clk);
        a = 8'h00; b = 8'h01; c = 8'h00; d = 8'h01;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            n_cmp++;
            if (y !== exp0[i]) begin
                n_bad++; $display("FAIL pat0101_sel%0d: got %h want %h", i, y, exp0[i]);
            end
            #4;
        end
        @(negedge clk);
        a = 8'h01; b = 8'h00; c = 8'h01; d = 8'h00;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            n_cmp++;
            if (y !== exp1[i]) begin
                n_bad++; $display("FAIL pat1010_sel%0d: got %h want %h", i, y, exp1[i]);
            end
            #4;
        end
    endtask

    task automatic test_x_masking();
        logic [W-1:0] xv;
        xv = 'x;
        @(negedge clk);
        a = xv; b = 8'h01; c = 8'h00; d = 8'h00; sel = 2'b00;
        #1;
        n_cmp++;
        if (y !== xv) begin
            n_bad++; $display("FAIL x_selected: got %h want %h", y, xv);
        end
        sel = 2'b01;
        #1;
        n_cmp++;
        if (y !== 8'h01) begin
            n_bad++; $display("FAIL x_masked: got %h want %h", y, 8'h01);
        end
    endtask

    task automatic test_between_edges();
        @(negedge clk);
        a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44; sel = 2'b01;
        @(posedge clk);
        #1;
        n_cmp++;
        if (y_q !== 8'h22) begin
            n_bad++; $display("FAIL between_capture: got %h want %h", y_q, 8'h22);
        end
        @(negedge clk);
        sel = 2'b10;
        #1;
        n_cmp++;
        if (y !== 8'h33) begin
            n_bad++; $display("FAIL between_y_now: got %h want %h", y, 8'h33);
        end
        n_cmp++;
        if (y_q !== 8'h22) begin
            n_bad++; $display("FAIL between_y_q_held: got %h want %h", y_q, 8'h22);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (y_q !== 8'h33 || sel_q !== 2'b10) begin
            n_bad++; $display("FAIL between_next_edge: got %h/%b want %h/%b", y_q, sel_q, 8'h33, 2'b10);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   seq [4];
        logic [W-1:0] exp [4];
        seq = '{2'b11, 2'b00, 2'b10, 2'b01};
        exp = '{8'hD4, 8'hA1, 8'hC3, 8'hB2};
        @(negedge clk);
        a = 8'hA1; b = 8'hB2; c = 8'hC3; d = 8'hD4;
        for (int i = 0; i < 4; i++) begin
            sel = seq[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if (y_q !== exp[i]) begin
                n_bad++; $display("FAIL b2b_y_q_%0d: got %h want %h", i, y_q, exp[i]);
            end
            n_cmp++;
            if (sel_q !== seq[i]) begin
                n_bad++; $display("FAIL b2b_sel_q_%0d: got %b want %b", i, sel_q, seq[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_parity();
        @(negedge clk);
        a = 8'hA5; b = 8'h00; c = 8'h00; d = 8'h00; sel = 2'b00;
        #1;
        n_cmp++;
        if (y !== 8'hA5) begin
            n_bad++; $display("FAIL par_y: got %h want %h", y, 8'hA5);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (y_q !== 8'hA5) begin
            n_bad++; $display("FAIL par_y_q: got %h want %h", y_q, 8'hA5);
        end
`ifdef MUX4_PARITY_EN
        n_cmp++;
        if (par_q !== 1'b0) begin
            n_bad++; $display("FAIL par_even: got %b want %b", par_q, 1'b0);
        end
`endif
        @(negedge clk);
        d = 8'h01; sel = 2'b11;
        @(posedge clk);
        #1;
        n_cmp++;
        if (y_q !== 8'h01) begin
            n_bad++; $display("FAIL par_d_y_q: got %h want %h", y_q, 8'h01);
        end
`ifdef MUX4_PARITY_EN
        n_cmp++;
        if (par_q !== 1'b1) begin
            n_bad++; $display("FAIL par_odd: got %b want %b", par_q, 1'b1);
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        a = '0; b = '0; c = '0; d = '0; sel = 2'b00;
        test_reset();
        test_patterns();
        test_x_masking();
        test_between_edges();
        test_back_to_back();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
